// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encodings, instruction field positions and
// the operation encodings that make up the harmless fault instruction.
package cpu_pkg;

    localparam logic [1:0] STATE_IDLE    = 2'b00;
    localparam logic [1:0] STATE_REQUEST = 2'b01;
    localparam logic [1:0] STATE_WAIT    = 2'b10;
    localparam logic [1:0] STATE_DONE    = 2'b11;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int FIELD_WIDTH       = 4;
    localparam int IMMEDIATE_WIDTH   = 8;

    // Nibble index of each field within the instruction word (0 = bits 3:0).
    localparam int OPERATION_NIBBLE       = 3;
    localparam int DESTINATION_NIBBLE     = 2;
    localparam int OPERATION_EXTRA_NIBBLE = 1;
    localparam int SOURCE_NIBBLE          = 0;

    localparam logic [3:0] OPERATION_RTYPE = 4'h0;
    localparam logic [3:0] EXTRA_OR        = 4'h2;

    // OR r0,r0: a no-op the controller can execute safely after a timeout.
    localparam logic [15:0] CPU_FAULT_WORD = {OPERATION_RTYPE, 4'h0, EXTRA_OR, 4'h0};

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: registered request/address from the fetch unit,
// ready/valid/data from memory.
interface instruction_fetch_unit_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int WORD_WIDTH    = 16
);

    logic                     memory_read_request;
    logic [ADDRESS_WIDTH-1:0] memory_address;
    logic                     memory_read_ready;
    logic                     memory_read_valid;
    logic [WORD_WIDTH-1:0]    memory_read_data;

    modport master (
        output memory_read_request,
        output memory_address,
        input  memory_read_ready,
        input  memory_read_valid,
        input  memory_read_data
    );

    modport slave (
        input  memory_read_request,
        input  memory_address,
        output memory_read_ready,
        output memory_read_valid,
        output memory_read_data
    );

endinterface

// File: rtl/instruction_fetch_unit_field_split.sv
// Combinational split of a 16-bit instruction word into its decode fields;
// shared with the disassembly monitor.
module instruction_field_split
    import cpu_pkg::*;
(
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_word,
    output logic [FIELD_WIDTH-1:0]       instruction_operation,
    output logic [FIELD_WIDTH-1:0]       instruction_destination,
    output logic [FIELD_WIDTH-1:0]       instruction_operation_extra,
    output logic [FIELD_WIDTH-1:0]       instruction_source,
    output logic [IMMEDIATE_WIDTH-1:0]   instruction_immediate
);

    localparam int NIBBLE_COUNT = INSTRUCTION_WIDTH / FIELD_WIDTH;

    logic [FIELD_WIDTH-1:0] nibble [NIBBLE_COUNT];

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLE_COUNT; gi++) begin : g_nibble
            assign nibble[gi] = instruction_word[gi*FIELD_WIDTH +: FIELD_WIDTH];
        end
    endgenerate

    assign instruction_operation       = nibble[OPERATION_NIBBLE];
    assign instruction_destination     = nibble[DESTINATION_NIBBLE];
    assign instruction_operation_extra = nibble[OPERATION_EXTRA_NIBBLE];
    assign instruction_source          = nibble[SOURCE_NIBBLE];
    assign instruction_immediate       = instruction_word[IMMEDIATE_WIDTH-1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one instruction word per command over a stallable request/valid port.
// Define FETCH_TIMEOUT_EN to bound the wait and substitute FAULT_WORD on expiry.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDRESS_WIDTH  = 16,
    parameter int          WORD_WIDTH     = 16,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [15:0] FAULT_WORD     = CPU_FAULT_WORD
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_start,
    input  logic [ADDRESS_WIDTH-1:0] fetch_address,
    instruction_fetch_unit_if.master memory_bus,
    output logic                     fetch_busy,
    output logic                     fetch_done,
    output logic [15:0]              instruction,
    output logic [3:0]               instruction_operation,
    output logic [3:0]               instruction_destination,
    output logic [3:0]               instruction_operation_extra,
    output logic [3:0]               instruction_source,
    output logic [7:0]               instruction_immediate,
    output logic                     fetch_fault
);

    generate
        if (WORD_WIDTH != 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("instruction_fetch_unit: WORD_WIDTH must be 16 and TIMEOUT_CYCLES at least 2");
        end
    endgenerate

    logic [1:0]               state_reg, state_next;
    logic                     request_reg, request_next;
    logic [ADDRESS_WIDTH-1:0] address_reg, address_next;
    logic [15:0]              instruction_reg, instruction_next;
    logic                     done_reg;
    logic                     timeout_taken;

`ifdef FETCH_TIMEOUT_EN
    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST  = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] wait_count_reg;
    logic                   waiting;
    logic                   fault_reg;

    assign waiting = (state_reg == STATE_REQUEST) || (state_reg == STATE_WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count_reg <= '0;
        end else if (state_reg == STATE_IDLE) begin
            wait_count_reg <= '0;
        end else if (waiting && wait_count_reg != COUNT_LIMIT) begin
            wait_count_reg <= wait_count_reg + 1'b1;
        end
    end

    // The counter reaches the limit on this edge; returning data takes priority.
    assign timeout_taken = waiting && (wait_count_reg == COUNT_LAST) &&
                           !(state_reg == STATE_WAIT && memory_bus.memory_read_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_reg <= 1'b0;
        end else if (timeout_taken) begin
            fault_reg <= 1'b1;
        end
    end

    assign fetch_fault = fault_reg;
`else
    assign timeout_taken = 1'b0;
    assign fetch_fault   = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        request_next     = request_reg;
        address_next     = address_reg;
        instruction_next = instruction_reg;
        case (state_reg)
            STATE_IDLE: begin
                if (fetch_start) begin
                    address_next = fetch_address;
                    request_next = 1'b1;
                    state_next   = STATE_REQUEST;
                end
            end
            STATE_REQUEST: begin
                if (timeout_taken) begin
                    request_next     = 1'b0;
                    instruction_next = FAULT_WORD;
                    state_next       = STATE_DONE;
                end else if (memory_bus.memory_read_ready) begin
                    request_next = 1'b0;
                    state_next   = STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                if (memory_bus.memory_read_valid) begin
                    instruction_next = memory_bus.memory_read_data;
                    state_next       = STATE_DONE;
                end else if (timeout_taken) begin
                    instruction_next = FAULT_WORD;
                    state_next       = STATE_DONE;
                end
            end
            default: begin
                state_next = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= STATE_IDLE;
            request_reg     <= 1'b0;
            address_reg     <= '0;
            instruction_reg <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            request_reg     <= request_next;
            address_reg     <= address_next;
            instruction_reg <= instruction_next;
            done_reg        <= (state_next == STATE_DONE);
        end
    end

    assign memory_bus.memory_read_request = request_reg;
    assign memory_bus.memory_address      = address_reg;
    assign fetch_busy                     = (state_reg != STATE_IDLE);
    assign fetch_done                     = done_reg;
    assign instruction                    = instruction_reg;

    instruction_field_split u_field_split (
        .instruction_word            (instruction_reg),
        .instruction_operation       (instruction_operation),
        .instruction_destination     (instruction_destination),
        .instruction_operation_extra (instruction_operation_extra),
        .instruction_source          (instruction_source),
        .instruction_immediate       (instruction_immediate)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; a cycle-accurate memory responder
// is driven from run_fetch, timeout cases are built with FETCH_TIMEOUT_EN.
module tb_instruction_fetch_unit;

    localparam int AW = 16;
    localparam int WW = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [15:0] fetch_address;
    logic        fetch_busy, fetch_done, fetch_fault;
    logic [15:0] instruction;
    logic [3:0]  instruction_operation, instruction_destination;
    logic [3:0]  instruction_operation_extra, instruction_source;
    logic [7:0]  instruction_immediate;

    instruction_fetch_unit_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) memory_bus ();

    instruction_fetch_unit #(
        .ADDRESS_WIDTH  (AW),
        .WORD_WIDTH     (WW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .fetch_start                 (fetch_start),
        .fetch_address               (fetch_address),
        .memory_bus                  (memory_bus),
        .fetch_busy                  (fetch_busy),
        .fetch_done                  (fetch_done),
        .instruction                 (instruction),
        .instruction_operation       (instruction_operation),
        .instruction_destination     (instruction_destination),
        .instruction_operation_extra (instruction_operation_extra),
        .instruction_source          (instruction_source),
        .instruction_immediate       (instruction_immediate),
        .fetch_fault                 (fetch_fault)
    );

    always #5 clock = ~clock;

    int vectors_applied = 0;
    int miscompares     = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    // Called just after a rising edge with the DUT idle. Cycle 0 carries fetch_start.
    // ready rises in cycle 1+ready_delay; valid pulses valid_delay cycles after acceptance.
    task automatic run_fetch(input logic [15:0] addr, input logic [15:0] data,
                             input int ready_delay, input int valid_delay,
                             input int extra_start_cycle, input int budget,
                             output int done_cycle, output int done_count,
                             output int req_starts, output bit addr_stable);
        int   accepted;
        logic prev_req;
        accepted    = -1;
        done_cycle  = -1;
        done_count  = 0;
        req_starts  = 0;
        addr_stable = 1'b1;
        prev_req    = 1'b0;
        fetch_address = addr;
        fetch_start   = 1'b1;
        @(posedge clock); #1;
        for (int c = 1; c <= budget; c++) begin
            fetch_start = (c == extra_start_cycle);
            if (c == extra_start_cycle) fetch_address = addr ^ 16'hFFFF;
            memory_bus.memory_read_ready = (c >= 1 + ready_delay);
            memory_bus.memory_read_valid = (accepted >= 0) && (c == accepted + valid_delay);
            memory_bus.memory_read_data  = memory_bus.memory_read_valid ? data : 16'hDEAD;
            @(negedge clock);
            if (memory_bus.memory_read_request && !prev_req) req_starts++;
            prev_req = memory_bus.memory_read_request;
            if (memory_bus.memory_read_request && memory_bus.memory_address !== addr) addr_stable = 1'b0;
            if (memory_bus.memory_read_request && memory_bus.memory_read_ready && accepted < 0) accepted = c;
            if (fetch_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            @(posedge clock); #1;
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
        end
        fetch_start                  = 1'b0;
        memory_bus.memory_read_ready = 1'b0;
        memory_bus.memory_read_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    int done_cycle, done_count, req_starts;
    bit addr_stable;

    initial begin
        reset                        = 1'b1;
        fetch_start                  = 1'b0;
        fetch_address                = '0;
        memory_bus.memory_read_ready = 1'b0;
        memory_bus.memory_read_valid = 1'b0;
        memory_bus.memory_read_data  = '0;
        apply_reset();

        @(negedge clock);
        check("reset_busy",        32'(fetch_busy), 32'h0);
        check("reset_request",     32'(memory_bus.memory_read_request), 32'h0);
        check("reset_address",     32'(memory_bus.memory_address), 32'h0);
        check("reset_instruction", 32'(instruction), 32'h0);
        check("reset_done",        32'(fetch_done), 32'h0);
        check("reset_fault",       32'(fetch_fault), 32'h0);
        @(posedge clock); #1;

        // Zero-wait memory.
        run_fetch(16'h0010, 16'h5312, 0, 1, -1, 20, done_cycle, done_count, req_starts, addr_stable);
        check("zw_done_cycle",  32'(done_cycle), 32'd3);
        check("zw_done_count",  32'(done_count), 32'd1);
        check("zw_req_starts",  32'(req_starts), 32'd1);
        check("zw_addr_stable", 32'(addr_stable), 32'd1);
        check("zw_instruction", 32'(instruction), 32'h5312);
        check("zw_operation",   32'(instruction_operation), 32'h5);
        check("zw_destination", 32'(instruction_destination), 32'h3);
        check("zw_extra",       32'(instruction_operation_extra), 32'h1);
        check("zw_source",      32'(instruction_source), 32'h2);
        check("zw_immediate",   32'(instruction_immediate), 32'h12);

        // Stalled memory; a start in the DONE cycle must be ignored.
        run_fetch(16'h0234, 16'hA7C4, 4, 3, 9, 30, done_cycle, done_count, req_starts, addr_stable);
        check("st_done_cycle",  32'(done_cycle), 32'd9);
        check("st_done_count",  32'(done_count), 32'd1);
        check("st_req_starts",  32'(req_starts), 32'd1);
        check("st_addr_stable", 32'(addr_stable), 32'd1);
        check("st_instruction", 32'(instruction), 32'hA7C4);
        check("st_operation",   32'(instruction_operation), 32'hA);
        check("st_immediate",   32'(instruction_immediate), 32'hC4);

        // Spurious valid in IDLE.
        memory_bus.memory_read_valid = 1'b1;
        memory_bus.memory_read_data  = 16'hFFFF;
        @(posedge clock); #1;
        memory_bus.memory_read_valid = 1'b0;
        @(negedge clock);
        check("sp_idle_instruction", 32'(instruction), 32'hA7C4);
        check("sp_idle_busy",        32'(fetch_busy), 32'h0);
        check("sp_idle_done",        32'(fetch_done), 32'h0);
        @(posedge clock); #1;

        // Spurious fetch_start during WAIT.
        run_fetch(16'h0100, 16'h1E5B, 1, 2, 3, 30, done_cycle, done_count, req_starts, addr_stable);
        check("sp_done_cycle",  32'(done_cycle), 32'd5);
        check("sp_done_count",  32'(done_count), 32'd1);
        check("sp_req_starts",  32'(req_starts), 32'd1);
        check("sp_addr_stable", 32'(addr_stable), 32'd1);
        check("sp_address",     32'(memory_bus.memory_address), 32'h0100);
        check("sp_instruction", 32'(instruction), 32'h1E5B);

        // Reset during WAIT, then a late valid.
        fetch_address = 16'h0300;
        fetch_start   = 1'b1;
        @(posedge clock); #1;
        fetch_start                  = 1'b0;
        memory_bus.memory_read_ready = 1'b1;
        @(posedge clock); #1;
        memory_bus.memory_read_ready = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("rm_busy_in_wait", 32'(fetch_busy), 32'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rm_busy",        32'(fetch_busy), 32'h0);
        check("rm_request",     32'(memory_bus.memory_read_request), 32'h0);
        check("rm_instruction", 32'(instruction), 32'h0);
        check("rm_address",     32'(memory_bus.memory_address), 32'h0);
        @(posedge clock); #1;
        memory_bus.memory_read_valid = 1'b1;
        memory_bus.memory_read_data  = 16'h4444;
        @(posedge clock); #1;
        memory_bus.memory_read_valid = 1'b0;
        @(negedge clock);
        check("rm_late_instruction", 32'(instruction), 32'h0);
        check("rm_late_done",        32'(fetch_done), 32'h0);
        check("rm_late_busy",        32'(fetch_busy), 32'h0);
        @(posedge clock); #1;

`ifdef FETCH_TIMEOUT_EN
        // Tie: valid lands on the eighth waiting cycle, the one that would time out.
        run_fetch(16'h0400, 16'h6789, 0, 7, -1, 30, done_cycle, done_count, req_starts, addr_stable);
        check("tie_done_cycle",  32'(done_cycle), 32'd9);
        check("tie_instruction", 32'(instruction), 32'h6789);
        check("tie_fault",       32'(fetch_fault), 32'h0);

        // Memory never answers.
        run_fetch(16'h0500, 16'h1111, 0, 1000, -1, 30, done_cycle, done_count, req_starts, addr_stable);
        check("to_done_cycle",  32'(done_cycle), 32'd9);
        check("to_done_count",  32'(done_count), 32'd1);
        check("to_instruction", 32'(instruction), 32'h0020);
        check("to_fault",       32'(fetch_fault), 32'h1);
`else
        // Without the timeout a long stall must simply be waited out.
        run_fetch(16'h0600, 16'h2222, 20, 30, -1, 80, done_cycle, done_count, req_starts, addr_stable);
        check("ls_done_cycle",  32'(done_cycle), 32'd52);
        check("ls_done_count",  32'(done_count), 32'd1);
        check("ls_addr_stable", 32'(addr_stable), 32'd1);
        check("ls_instruction", 32'(instruction), 32'h2222);
        check("ls_fault",       32'(fetch_fault), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
